// File: rtl/microcode_sequencer_if.sv
// Bundle of opcode/flag inputs, datapath strobes and status outputs of the
// microcode sequencer. The master side is the sequencer itself.
interface microcode_sequencer_if #(
    parameter int NREG   = 2,
    parameter int STEP_W = 4
);
    logic [7:0]        opcode;
    logic              carry_flag;
    logic              zero_flag;
    logic              run;

    logic              pc_en, pc_inc, pc_load, mar_load;
    logic              ram_ce, ram_we, mdr_load, mdr_oe;
    logic              mdr_sel_hi, mdr_src_bus, ir_load, acc_load;
    logic              acc_oe, alu_oe, alu_sub, tmp_load;
    logic              tmp_oe, out_load;
    logic [NREG-1:0]   reg_load;
    logic [NREG-1:0]   reg_oe;
    logic [STEP_W-1:0] step;
    logic              instr_done, illegal, halted;

    modport master (
        input  opcode, carry_flag, zero_flag, run,
        output pc_en, pc_inc, pc_load, mar_load, ram_ce, ram_we, mdr_load,
               mdr_oe, mdr_sel_hi, mdr_src_bus, ir_load, acc_load, acc_oe,
               alu_oe, alu_sub, tmp_load, tmp_oe, out_load, reg_load, reg_oe,
               step, instr_done, illegal, halted
    );

    modport slave (
        output opcode, carry_flag, zero_flag, run,
        input  pc_en, pc_inc, pc_load, mar_load, ram_ce, ram_we, mdr_load,
               mdr_oe, mdr_sel_hi, mdr_src_bus, ir_load, acc_load, acc_oe,
               alu_oe, alu_sub, tmp_load, tmp_oe, out_load, reg_load, reg_oe,
               step, instr_done, illegal, halted
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches 1..3 instruction bytes in 4-cycle groups,
// then runs up to two execute cycles, issuing one-cycle datapath strobes.
// State is FETCH (byte_q/phase_q select the fetch cycle), EXEC (phase_q is
// the execute cycle) or HALT. Strobes are decoded from state and opcode;
// only the JC/JZ jump strobes also look at the live flags.
module microcode_sequencer #(
    parameter int NREG   = 2,
    parameter int STEP_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    microcode_sequencer_if.master bus
);
    localparam logic [3:0] C_LDA = 4'h0, C_STA = 4'h1, C_ADD = 4'h2, C_SUB = 4'h3;
    localparam logic [3:0] C_JMP = 4'h4, C_JC = 4'h5, C_JZ = 4'h6, C_OUT = 4'h7;
    localparam logic [3:0] C_HLT = 4'h8, C_MVA = 4'h9, C_MVR = 4'hA, C_MOV = 4'hB;
    localparam logic [3:0] C_NOP = 4'hC;

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_q, byte_d;
    logic [1:0]          phase_q, phase_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                illegal_q, illegal_d;

    logic [3:0]          cls, r, eff_cls;
    logic                is_illegal, last_fetch, exec_last;
    logic [1:0]          nbytes, exec_len;
    logic [NREG-1:0]     reg_onehot;

    // Instruction decode: illegal opcodes are folded into NOP.
    always_comb begin
        cls        = bus.opcode[7:4];
        r          = bus.opcode[3:0];
        is_illegal = (cls >= 4'hD) ||
                     (((cls == C_ADD) || (cls == C_SUB) || (cls == C_MVR) || (cls == C_MOV))
                      && !(32'(r) < NREG));
        eff_cls    = is_illegal ? C_NOP : cls;
        case (eff_cls)
            C_LDA, C_STA, C_JMP, C_JC, C_JZ: nbytes = 2'd3;
            C_MVA, C_MVR:                    nbytes = 2'd2;
            default:                         nbytes = 2'd1;
        endcase
        case (eff_cls)
            C_LDA, C_STA, C_ADD, C_SUB: exec_len = 2'd2;
            C_OUT, C_MOV:               exec_len = 2'd1;
            default:                    exec_len = 2'd0;
        endcase
        reg_onehot = NREG'(1) << r;
        last_fetch = (byte_q == nbytes);
        exec_last  = (phase_q == exec_len - 2'd1);
    end

    // Sequencing state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            byte_q    <= 2'd1;
            phase_q   <= 2'd0;
            step_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            phase_q   <= phase_d;
            step_q    <= step_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state: advance fetch phases/bytes, then execute cycles, then wrap.
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        phase_d   = phase_q;
        step_d    = step_q;
        illegal_d = 1'b0;
        case (state_q)
            FETCH: begin
                step_d  = step_q + STEP_W'(1);
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    if (!last_fetch) begin
                        byte_d = byte_q + 2'd1;
                    end else begin
                        byte_d = 2'd1;
                        if (exec_len != 2'd0) begin
                            state_d = EXEC;
                        end else begin
                            step_d    = '0;
                            illegal_d = is_illegal;
                            if (eff_cls == C_HLT) state_d = HALT;
                        end
                    end
                end
            end
            EXEC: begin
                if (exec_last) begin
                    state_d = FETCH;
                    phase_d = 2'd0;
                    step_d  = '0;
                end else begin
                    phase_d = phase_q + 2'd1;
                    step_d  = step_q + STEP_W'(1);
                end
            end
            default: begin
                step_d  = '0;
                phase_d = 2'd0;
                byte_d  = 2'd1;
                if (bus.run) state_d = FETCH;
            end
        endcase
    end

    // Strobe decode; everything is forced low while reset is asserted.
    always_comb begin
        bus.pc_en = 1'b0;  bus.pc_inc = 1'b0;  bus.pc_load = 1'b0;  bus.mar_load = 1'b0;
        bus.ram_ce = 1'b0; bus.ram_we = 1'b0;  bus.mdr_load = 1'b0; bus.mdr_oe = 1'b0;
        bus.mdr_sel_hi = 1'b0; bus.mdr_src_bus = 1'b0; bus.ir_load = 1'b0;
        bus.acc_load = 1'b0; bus.acc_oe = 1'b0; bus.alu_oe = 1'b0; bus.alu_sub = 1'b0;
        bus.tmp_load = 1'b0; bus.tmp_oe = 1'b0; bus.out_load = 1'b0;
        bus.reg_load = '0; bus.reg_oe = '0;
        bus.step = '0; bus.instr_done = 1'b0; bus.illegal = 1'b0; bus.halted = 1'b0;
        if (rst_n) begin
            bus.step    = step_q;
            bus.illegal = illegal_q;
            case (state_q)
                FETCH: begin
                    case (phase_q)
                        2'd0: begin bus.pc_en = 1'b1; bus.mar_load = 1'b1; end
                        2'd1: bus.pc_inc = 1'b1;
                        2'd2: begin bus.ram_ce = 1'b1; bus.mdr_load = 1'b1; end
                        default: begin
                            bus.instr_done = last_fetch && (exec_len == 2'd0);
                            if (byte_q == 2'd1) begin
                                bus.mdr_oe  = 1'b1;
                                bus.ir_load = 1'b1;
                            end else if (byte_q == 2'd2) begin
                                bus.mdr_oe = 1'b1;
                                if (eff_cls == C_MVA)      bus.acc_load = 1'b1;
                                else if (eff_cls == C_MVR) bus.reg_load = reg_onehot;
                                else                       bus.tmp_load = 1'b1;
                            end else if ((eff_cls == C_JMP) || (eff_cls == C_LDA) ||
                                         (eff_cls == C_STA) ||
                                         ((eff_cls == C_JC) && bus.carry_flag) ||
                                         ((eff_cls == C_JZ) && bus.zero_flag)) begin
                                bus.mdr_oe     = 1'b1;
                                bus.mdr_sel_hi = 1'b1;
                                bus.tmp_oe     = 1'b1;
                                if ((eff_cls == C_LDA) || (eff_cls == C_STA)) bus.mar_load = 1'b1;
                                else                                          bus.pc_load  = 1'b1;
                            end
                        end
                    endcase
                end
                EXEC: begin
                    bus.instr_done = exec_last;
                    case (eff_cls)
                        C_ADD, C_SUB: begin
                            if (phase_q == 2'd0) begin
                                bus.reg_oe = reg_onehot; bus.tmp_load = 1'b1;
                            end else begin
                                bus.alu_oe = 1'b1; bus.acc_load = 1'b1;
                                bus.alu_sub = (eff_cls == C_SUB);
                            end
                        end
                        C_MOV: begin bus.acc_oe = 1'b1; bus.reg_load = reg_onehot; end
                        C_OUT: begin bus.acc_oe = 1'b1; bus.out_load = 1'b1; end
                        C_LDA: begin
                            if (phase_q == 2'd0) begin bus.ram_ce = 1'b1; bus.mdr_load = 1'b1; end
                            else begin bus.mdr_oe = 1'b1; bus.acc_load = 1'b1; end
                        end
                        C_STA: begin
                            if (phase_q == 2'd0) begin
                                bus.acc_oe = 1'b1; bus.mdr_src_bus = 1'b1; bus.mdr_load = 1'b1;
                            end else begin
                                bus.ram_ce = 1'b1; bus.ram_we = 1'b1; bus.mdr_oe = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: bus.halted = 1'b1;
            endcase
        end
    end
endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 SHALL have parameter NREG, default 2: number of general registers (1..15), indexed by opcode[3:0].
REQ-002 SHALL have parameter STEP_W, default 4: width of the step output.
REQ-003 SHALL have these ports: clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have these ports: rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have these ports: opcode, input, 8, current instruction from the external IR; valid from the cycle after ir_load.
REQ-006 SHALL have these ports: carry_flag and zero_flag, input, 1 each, ALU flags.
REQ-007 SHALL have these ports: run, input, 1, leave HALT.
REQ-008 SHALL have these ports: pc_en, pc_inc, pc_load, mar_load, ram_ce, ram_we, mdr_load, mdr_oe, mdr_sel_hi, mdr_src_bus, ir_load, acc_load, acc_oe, alu_oe, alu_sub, tmp_load, tmp_oe, out_load; output; 1 each; datapath strobes.
REQ-009 SHALL have these ports: reg_load and reg_oe, output, NREG each, one-hot per-register strobes.
REQ-010 SHALL have these ports: step, output, STEP_W, cycle index within the current instruction.
REQ-011 SHALL have these ports: instr_done, illegal and halted, output, 1 each, status.

Function
REQ-012 SHALL decode class = opcode[7:4] and r = opcode[3:0] as follows: 0 LDA, 1 STA, 2 ADD r, 3 SUB r, 4 JMP, 5 JC, 6 JZ, 7 OUT, 8 HLT, 9 MVI A, A MVI r, B MOV A->r, C NOP.
REQ-013 SHALL treat classes D-F, and any r >= NREG for classes 2, 3, A and B, as illegal: illegal = 1 for one cycle at step 4, then behave as NOP.
REQ-014 SHALL size instructions as: LDA, STA, JMP, JC and JZ are 3 bytes; MVI is 2 bytes; all others are 1 byte.
REQ-015 SHALL fetch each byte in 4 cycles: F0 pc_en+mar_load; F1 pc_inc; F2 ram_ce+mdr_load; F3 mdr_oe plus a byte-specific load.
REQ-016 SHALL make the byte-specific F3 loads: byte1 ir_load; MVI byte2 acc_load (MVI A) or reg_load[r]; 3-byte byte2 tmp_load.
REQ-017 SHALL make byte3 F3 assert mdr_sel_hi+tmp_oe with mar_load for LDA/STA, or with pc_load for JMP.
REQ-018 SHALL make byte3 F3 for JC/JZ assert pc_load, mdr_oe, mdr_sel_hi and tmp_oe only when carry_flag/zero_flag is 1 in that same cycle; otherwise assert none of them.
REQ-019 SHALL execute after the last fetch: ADD/SUB E0 reg_oe[r]+tmp_load, E1 alu_oe+acc_load (alu_sub=1 for SUB); MOV E0 acc_oe+reg_load[r]; OUT E0 acc_oe+out_load.
REQ-020 SHALL execute LDA as E0 ram_ce+mdr_load, E1 mdr_oe+acc_load.
REQ-021 SHALL execute STA as E0 acc_oe+mdr_src_bus+mdr_load, E1 ram_ce+ram_we+mdr_oe.
REQ-022 SHALL give these instruction lengths in cycles: NOP/illegal/HLT 4; MOV/OUT 5; ADD/SUB 6; MVI 8; JMP/JC/JZ 12; LDA/STA 14.
REQ-023 SHALL pulse instr_done in the last cycle of each instruction and start the next fetch F0 (step = 0) on the following cycle, with no idle cycles.
REQ-024 SHALL make step count 0 at F0 of byte1 and increment by 1 per cycle.
REQ-025 SHALL make all outputs Moore functions of registered state and opcode, except the JC/JZ flag qualification.
REQ-026 SHALL keep every unlisted strobe 0, with reg_load and reg_oe at most one-hot.
REQ-027 SHALL have states FETCH, EXEC and HALT; HLT enters HALT after its step 3.
REQ-028 SHALL in HALT hold halted = 1, hold all strobes at 0 and hold step at 0.
REQ-029 SHALL leave HALT for FETCH F0 on the cycle after run = 1 is sampled; run is ignored outside HALT.
REQ-030 SHALL not alter the sequence if opcode changes after ir_load; it is sampled for decode continuously, and the datapath holds the IR.

Reset
REQ-031 SHALL, while rst_n = 0 (asynchronously, including mid-instruction), force state = FETCH, byte = 1, phase F0 and step = 0.
REQ-032 SHALL, while rst_n = 0, hold all strobes, instr_done, illegal and halted at 0.
REQ-033 SHALL, on the first rising clk edge after rst_n deasserts, issue F0 (pc_en = 1, mar_load = 1) in that cycle.

Verification
REQ-034 SHALL cover: opcode 0x21 (ADD r1), NREG = 2 -> step 4 reg_oe = 2'b10 + tmp_load; step 5 alu_oe + acc_load, alu_sub = 0, instr_done = 1; step 0 next cycle.
REQ-035 SHALL cover: opcode 0x50 (JC), carry_flag = 0 at step 11 -> no pc_load, instr_done at step 11; repeat with carry_flag = 1 -> pc_load + mdr_sel_hi + tmp_oe at step 11.
REQ-036 SHALL cover: opcode 0x10 (STA) -> step 13 ram_ce + ram_we + mdr_oe, instr_done = 1; 14 cycles total.
REQ-037 SHALL cover: opcode 0x80 (HLT) -> halted = 1 from step 4; strobes stay 0 for 20 cycles; run = 1 pulse -> pc_en + mar_load on the next cycle.
REQ-038 SHALL cover: opcode 0x25 with NREG = 2 -> illegal pulse at step 4, no reg_oe, instr_done at step 3, next fetch.
REQ-039 SHALL cover: rst_n low at step 7 of LDA -> all outputs 0 immediately; after release, step 0 with F0 strobes.
